bnn_pin_driver: RTL and testbench
=================================

// Module: bnn_pin_driver
// PURPOSE
//  Host-side initiator for the tiny BNN pin interface: drives the 8-bit dedicated-input bus
//  (bnn clock, setup, serial param bit, x bank select, x nibble) and captures the 8-bit result bus.
//  Serially loads NUM_PARAM_BITS weights from a byte stream, then runs one inference per x byte.
//  Sits between an on-chip controller/FIFO and the BNN core's ui_in/uo_out.
// PARAMETERS
//  NUM_PARAM_BITS  112  weight/threshold bits shifted in per configuration
//  CLK_DIV         2    clk cycles per bnn-clock half period (>=1)
//  SETTLE_CYCLES   4    clk cycles bnn clock held low before sampling result (>=1)
// PORTS
//  clk           in   1  system clock
//  rst           in   1  synchronous active-high reset
//  cfg_start     in   1  pulse: begin parameter load (ignored unless IDLE)
//  param_valid   in   1  param byte valid
//  param_ready   out  1  param byte accepted when valid&ready
//  param_data    in   8  param byte, shifted LSB first
//  x_valid       in   1  input vector valid
//  x_ready       out  1  high in IDLE when loaded=1
//  x_data        in   8  input vector; [3:0] low bank, [7:4] high bank
//  res_valid     out  1  one-cycle pulse, res_data valid
//  res_data      out  8  captured result
//  busy          out  1  high whenever FSM != IDLE
//  loaded        out  1  high after a complete load; cleared by rst or cfg_start
//  param_crc     out  8  CRC-8 of loaded bits (see CONFIGURATION)
//  pin_ui_o      out  8  {x_nibble[3:0], bank_hi, param_in, setup, bnn_clk}
//  pin_uo_i      in   8  BNN result bus
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, phase counter 0, loaded=0.
//  Bit period = 2*CLK_DIV clk; phase ph 0..2*CLK_DIV-1; bnn_clk = (ph >= CLK_DIV).
//  Pin data fields change only at ph==0 (bnn_clk low); stable across the rising edge.
//  States: IDLE, LD_FETCH, LD_SHIFT, EV_LO, EV_HI, SETTLE, RESULT.
//  IDLE: cfg_start -> LD_FETCH, setup=1, loaded=0, bit count=0. cfg_start beats x_valid if both.
//   x_valid & loaded -> latch x_data, EV_LO. x_valid while !loaded: not accepted.
//  LD_FETCH: param_ready=1; on accept load shift reg, -> LD_SHIFT. While stalled bnn_clk stays 0
//   (no rising edge without a valid bit); setup stays 1.
//  LD_SHIFT: one bit period per bit, param_in = sreg[0]; after 8 bits -> LD_FETCH.
//   At bit count NUM_PARAM_BITS (final byte may be partial; unused upper bits discarded):
//   setup=0, param_in=0, loaded=1 -> IDLE. Exactly NUM_PARAM_BITS rising edges with setup=1.
//  EV_LO: one bit period, bank_hi=0, nibble=x[3:0]. EV_HI: one bit period, bank_hi=1, nibble=x[7:4].
//  SETTLE: bnn_clk=0, pins held, SETTLE_CYCLES clk. RESULT: res_data<=pin_uo_i, res_valid=1 one
//   cycle, -> IDLE. x_valid->res_valid latency = 4*CLK_DIV + SETTLE_CYCLES + 1 clk.
//  cfg_start/x_valid outside IDLE ignored. rst mid-operation: abort next edge, pins 0, loaded=0.
// CONFIGURATION
//  BNN_PIN_DRIVER_CRC_EN defined: param_crc = CRC-8 (poly 0x07, init 0x00, bit-serial MSB-first
//   update with each param_in bit at its rising edge); cleared on cfg_start; held after load.
//  Undefined: no CRC logic; param_crc tied 8'h00.
// STRUCTURE
//  Package bnn_pin_pkg: state enum; pin index constants PIN_CLK=0, PIN_SETUP=1, PIN_PARAM=2,
//   PIN_BANK=3, PIN_X_LSB=4; CRC8_POLY=8'h07.
//  Sub-module bnn_pin_clkgen: phase counter, bnn_clk, run enable, ph==0 and rising-edge ticks.
// TESTING (NUM_PARAM_BITS=12, CLK_DIV=2, SETTLE_CYCLES=4)
//  Reset: hold rst 3 cycles -> pin_ui_o=0, param_ready=0, res_valid=0, loaded=0, busy=0.
//  Load 0xA5,0x03 -> param_in at rising edges 1,0,1,0,0,1,0,1,1,1,0,0; 12 edges, setup=1; loaded=1.
//  Stall param_valid 10 cycles before byte 2 -> no bnn_clk edge, setup=1, loading resumes intact.
//  x=0x3C, pin_uo_i=0x5A -> edge with bank_hi=0 nibble 0xC, then bank_hi=1 nibble 0x3;
//   res_data=0x5A, res_valid single pulse 13 clk after accept.
//  rst after 5 loaded bits -> pin_ui_o=0 next cycle, loaded=0; then x_valid -> x_ready=0.
//  CRC_EN on: param_crc matches bit-serial CRC-8 model of 12 bits; off: param_crc=0x00.

Source files
------------

// File: rtl/bnn_pin_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bnn_pin_pkg
// Description : Shared types and constants for the BNN pin-interface driver.
//               FSM state encoding, pin bit positions on the 8-bit
//               dedicated-input bus, and the bit-serial CRC-8 step used to
//               fingerprint a loaded parameter set.
// Revision    : 1.0 - initial release
// ============================================================================
package bnn_pin_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LD_FETCH = 3'd1,
        LD_SHIFT = 3'd2,
        EV_LO    = 3'd3,
        EV_HI    = 3'd4,
        SETTLE   = 3'd5,
        RESULT   = 3'd6
    } state_t;

    // Bit positions on the BNN dedicated-input bus
    localparam int PIN_CLK   = 0;
    localparam int PIN_SETUP = 1;
    localparam int PIN_PARAM = 2;
    localparam int PIN_BANK  = 3;
    localparam int PIN_X_LSB = 4;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // One MSB-first CRC-8 update for a single serial bit
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage : bnn_pin_pkg
`default_nettype wire

// File: rtl/bnn_pin_clkgen.sv
`default_nettype none
// ============================================================================
// Module      : bnn_pin_clkgen
// Description : Bit-period timing for the BNN pin clock. A phase counter
//               runs 0..2*CLK_DIV-1 while enabled and parks at 0 otherwise,
//               so the BNN clock is low whenever the driver is not actively
//               clocking a bit.
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   i_run         in   enable phase counting
//   o_bnn_clk     out  BNN clock level (high in the second half period)
//   o_period_tick out  last phase of a bit period (phase returns to 0 next)
//   o_rise_tick   out  BNN clock rises on the next clk edge
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_pin_clkgen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    output logic o_bnn_clk,
    output logic o_period_tick,
    output logic o_rise_tick
);

    localparam int                c_PH_W    = $clog2(2 * CLK_DIV);
    localparam logic [c_PH_W-1:0] c_PH_LAST = c_PH_W'(2 * CLK_DIV - 1);
    localparam logic [c_PH_W-1:0] c_PH_RISE = c_PH_W'(CLK_DIV - 1);
    localparam logic [c_PH_W-1:0] c_PH_HIGH = c_PH_W'(CLK_DIV);

    logic [c_PH_W-1:0] r_ph;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ph <= '0;
        end else if (!i_run || (r_ph == c_PH_LAST)) begin
            r_ph <= '0;
        end else begin
            r_ph <= r_ph + c_PH_W'(1);
        end
    end

    assign o_bnn_clk     = (r_ph >= c_PH_HIGH);
    assign o_period_tick = i_run && (r_ph == c_PH_LAST);
    assign o_rise_tick   = i_run && (r_ph == c_PH_RISE);

endmodule : bnn_pin_clkgen
`default_nettype wire

// File: rtl/bnn_pin_driver.sv
`default_nettype none
// ============================================================================
// Module      : bnn_pin_driver
// Description : Host-side initiator for the tiny BNN pin interface. Serially
//               loads NUM_PARAM_BITS parameter bits from a byte stream (LSB
//               first), then runs one inference per accepted x byte: low
//               nibble on bank 0, high nibble on bank 1, settle, capture.
//   cfg_start   in   begin parameter load (IDLE only, wins over x_valid)
//   param_*     in/out  parameter byte handshake
//   x_*         in/out  input-vector handshake (accepted only once loaded)
//   res_valid   out  one-cycle pulse with res_data
//   busy        out  FSM not idle
//   loaded      out  complete parameter set present
//   param_crc   out  CRC-8 over loaded bits, or 0 when CRC is compiled out
//   pin_ui_o    out  {x_nibble, bank_hi, param_in, setup, bnn_clk}
//   pin_uo_i    in   BNN result bus
// Build option: define BNN_PIN_DRIVER_CRC_EN to include the CRC-8 logic.
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_pin_driver
    import bnn_pin_pkg::*;
#(
    parameter int NUM_PARAM_BITS = 112,
    parameter int CLK_DIV        = 2,
    parameter int SETTLE_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_start,
    input  logic       param_valid,
    output logic       param_ready,
    input  logic [7:0] param_data,
    input  logic       x_valid,
    output logic       x_ready,
    input  logic [7:0] x_data,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic       busy,
    output logic       loaded,
    output logic [7:0] param_crc,
    output logic [7:0] pin_ui_o,
    input  logic [7:0] pin_uo_i
);

    localparam int                 c_BC_W     = $clog2(NUM_PARAM_BITS + 1);
    localparam logic [c_BC_W-1:0]  c_BIT_LAST = c_BC_W'(NUM_PARAM_BITS);
    localparam int                 c_ST_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_ST_W-1:0]  c_ST_LAST  = c_ST_W'(SETTLE_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_sreg;
    logic [2:0]          r_byte_bit;
    logic [c_BC_W-1:0]   r_bit_cnt;
    logic [c_ST_W-1:0]   r_settle_cnt;
    logic [3:0]          r_x_hi;
    logic [3:0]          r_nibble;
    logic                r_bank_hi;
    logic                r_setup;
    logic                r_loaded;
    logic [7:0]          r_res_data;
    logic                r_res_valid;

    logic w_run;
    logic w_bnn_clk;
    logic w_period_tick;
    logic w_rise_tick;
    logic w_cfg_go;
    logic w_x_go;
    logic w_load_done;

    bnn_pin_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk           (clk),
        .rst           (rst),
        .i_run         (w_run),
        .o_bnn_clk     (w_bnn_clk),
        .o_period_tick (w_period_tick),
        .o_rise_tick   (w_rise_tick)
    );

    // cfg_start has priority over x_valid when both arrive in IDLE
    assign w_cfg_go    = (r_state == IDLE) && cfg_start;
    assign w_x_go      = (r_state == IDLE) && !cfg_start && x_valid && r_loaded;
    // Bit counter already reflects the current bit's rising edge by period end
    assign w_load_done = (r_state == LD_SHIFT) && w_period_tick && (r_bit_cnt == c_BIT_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_cfg_go) begin
                    w_state_nxt = LD_FETCH;
                end else if (w_x_go) begin
                    w_state_nxt = EV_LO;
                end
            end
            LD_FETCH: begin
                if (param_valid) begin
                    w_state_nxt = LD_SHIFT;
                end
            end
            LD_SHIFT: begin
                if (w_load_done) begin
                    w_state_nxt = IDLE;
                end else if (w_period_tick && (r_byte_bit == 3'd7)) begin
                    w_state_nxt = LD_FETCH;
                end
            end
            EV_LO: begin
                if (w_period_tick) begin
                    w_state_nxt = EV_HI;
                end
            end
            EV_HI: begin
                if (w_period_tick) begin
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (r_settle_cnt == c_ST_LAST) begin
                    w_state_nxt = RESULT;
                end
            end
            RESULT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        param_ready = 1'b0;
        x_ready     = 1'b0;
        busy        = 1'b1;
        w_run       = 1'b0;
        case (r_state)
            IDLE: begin
                busy    = 1'b0;
                x_ready = r_loaded;
            end
            LD_FETCH: param_ready = 1'b1;
            LD_SHIFT,
            EV_LO,
            EV_HI:    w_run = 1'b1;
            default:  ;
        endcase
    end

    // ---------------- Datapath ----------------
    // Pin data registers only change while the phase counter sits at 0,
    // so every field is stable across the following BNN clock rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg       <= '0;
            r_byte_bit   <= '0;
            r_bit_cnt    <= '0;
            r_settle_cnt <= '0;
            r_x_hi       <= '0;
            r_nibble     <= '0;
            r_bank_hi    <= 1'b0;
            r_setup      <= 1'b0;
            r_loaded     <= 1'b0;
            r_res_data   <= '0;
            r_res_valid  <= 1'b0;
        end else begin
            r_res_valid  <= 1'b0;
            r_settle_cnt <= (r_state == SETTLE) ? (r_settle_cnt + c_ST_W'(1)) : '0;
            case (r_state)
                IDLE: begin
                    if (w_cfg_go) begin
                        r_setup    <= 1'b1;
                        r_loaded   <= 1'b0;
                        r_bit_cnt  <= '0;
                        r_byte_bit <= '0;
                        r_sreg     <= '0;
                        r_nibble   <= '0;
                        r_bank_hi  <= 1'b0;
                    end else if (w_x_go) begin
                        r_x_hi    <= x_data[7:4];
                        r_nibble  <= x_data[3:0];
                        r_bank_hi <= 1'b0;
                    end
                end
                LD_FETCH: begin
                    if (param_valid) begin
                        r_sreg     <= param_data;
                        r_byte_bit <= '0;
                    end
                end
                LD_SHIFT: begin
                    if (w_rise_tick) begin
                        r_bit_cnt <= r_bit_cnt + c_BC_W'(1);
                    end
                    if (w_load_done) begin
                        // Unused upper bits of a partial final byte are dropped here
                        r_setup  <= 1'b0;
                        r_sreg   <= '0;
                        r_loaded <= 1'b1;
                    end else if (w_period_tick) begin
                        r_sreg     <= r_sreg >> 1;
                        r_byte_bit <= r_byte_bit + 3'd1;
                    end
                end
                EV_LO: begin
                    if (w_period_tick) begin
                        r_bank_hi <= 1'b1;
                        r_nibble  <= r_x_hi;
                    end
                end
                RESULT: begin
                    r_res_data  <= pin_uo_i;
                    r_res_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef BNN_PIN_DRIVER_CRC_EN
    logic [7:0] r_crc;

    // Fold in the serial bit exactly as the BNN samples it: on each rising edge
    always_ff @(posedge clk) begin
        if (rst || w_cfg_go) begin
            r_crc <= '0;
        end else if ((r_state == LD_SHIFT) && w_rise_tick) begin
            r_crc <= crc8_step(r_crc, r_sreg[0]);
        end
    end

    assign param_crc = r_crc;
`else
    assign param_crc = 8'h00;
`endif

    always_comb begin
        pin_ui_o                   = '0;
        pin_ui_o[PIN_CLK]          = w_bnn_clk;
        pin_ui_o[PIN_SETUP]        = r_setup;
        pin_ui_o[PIN_PARAM]        = r_sreg[0];
        pin_ui_o[PIN_BANK]         = r_bank_hi;
        pin_ui_o[PIN_X_LSB +: 4]   = r_nibble;
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign loaded    = r_loaded;

endmodule : bnn_pin_driver
`default_nettype wire

// File: tb/tb_bnn_pin_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_bnn_pin_driver
// Description : Directed self-checking bench for bnn_pin_driver with
//               NUM_PARAM_BITS=12, CLK_DIV=2, SETTLE_CYCLES=4. Honours
//               BNN_PIN_DRIVER_CRC_EN for the expected param_crc value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bnn_pin_driver;

    localparam int NPB = 12;
    localparam int CD  = 2;
    localparam int SC  = 4;

    logic       clk;
    logic       rst;
    logic       cfg_start;
    logic       param_valid;
    logic       param_ready;
    logic [7:0] param_data;
    logic       x_valid;
    logic       x_ready;
    logic [7:0] x_data;
    logic       res_valid;
    logic [7:0] res_data;
    logic       busy;
    logic       loaded;
    logic [7:0] param_crc;
    logic [7:0] pin_ui_o;
    logic [7:0] pin_uo_i;

    int n_vec = 0;
    int n_err = 0;

    // Snapshot of pin_ui_o at every observed BNN clock rising edge
    logic [7:0] edges[$];
    logic       prev_clk = 1'b0;

    bnn_pin_driver #(
        .NUM_PARAM_BITS (NPB),
        .CLK_DIV        (CD),
        .SETTLE_CYCLES  (SC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_start   (cfg_start),
        .param_valid (param_valid),
        .param_ready (param_ready),
        .param_data  (param_data),
        .x_valid     (x_valid),
        .x_ready     (x_ready),
        .x_data      (x_data),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .busy        (busy),
        .loaded      (loaded),
        .param_crc   (param_crc),
        .pin_ui_o    (pin_ui_o),
        .pin_uo_i    (pin_uo_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pin_ui_o[0] === 1'b1 && prev_clk === 1'b0) edges.push_back(pin_ui_o);
        prev_clk = pin_ui_o[0];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] crc_ref(input logic [11:0] bits);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 12; i++) begin
            if (c[7] ^ bits[i]) c = (c << 1) ^ 8'h07;
            else                c = c << 1;
        end
        return c;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting posedge
    task automatic send_byte(input logic [7:0] b);
        int t;
        param_data  = b;
        param_valid = 1'b1;
        t = 0;
        while (!param_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_vec("param_ready_wait", (t < 200), 1);
        @(negedge clk);
        param_valid = 1'b0;
    endtask

    initial begin
        int         t;
        logic       stall_hi;
        logic       stall_nosetup;
        logic [11:0] gb;
        logic [11:0] gs;
        logic [7:0] e0;
        logic [7:0] e1;
        logic [7:0] exp_crc;

`ifdef BNN_PIN_DRIVER_CRC_EN
        exp_crc = crc_ref(12'h3A5);
`else
        exp_crc = 8'h00;
`endif

        rst = 1'b1; cfg_start = 1'b0; param_valid = 1'b0; param_data = 8'h00;
        x_valid = 1'b0; x_data = 8'h00; pin_uo_i = 8'h00;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_vec("rst_pin_ui", pin_ui_o, 8'h00);
        check_vec("rst_param_ready", param_ready, 0);
        check_vec("rst_res_valid", res_valid, 0);
        check_vec("rst_loaded", loaded, 0);
        check_vec("rst_busy", busy, 0);
        check_vec("rst_x_ready", x_ready, 0);
        check_vec("rst_crc", param_crc, 8'h00);
        rst = 1'b0;

        // ---- parameter load 0xA5, stall, 0x03 ----
        @(negedge clk);
        edges.delete();
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        send_byte(8'hA5);
        t = 0;
        while (!param_ready && t < 200) begin @(negedge clk); t++; end
        check_vec("fetch2_wait", (t < 200), 1);
        stall_hi = 1'b0; stall_nosetup = 1'b0;
        repeat (10) begin
            @(negedge clk);
            stall_hi      |= pin_ui_o[0];
            stall_nosetup |= !pin_ui_o[1];
        end
        check_vec("stall_no_clk", stall_hi, 0);
        check_vec("stall_setup", stall_nosetup, 0);
        check_vec("stall_edges", edges.size(), 8);
        check_vec("stall_loaded", loaded, 0);
        send_byte(8'h03);
        t = 0;
        while (!loaded && t < 200) begin @(negedge clk); t++; end
        check_vec("load_done", loaded, 1);
        check_vec("load_edges", edges.size(), 12);
        gb = '0; gs = '0;
        for (int i = 0; i < 12; i++) begin
            if (i < edges.size()) begin
                gb[i] = edges[i][2];
                gs[i] = edges[i][1];
            end
        end
        check_vec("load_param_bits", gb, 12'h3A5);
        check_vec("load_setup_bits", gs, 12'hFFF);
        check_vec("load_pins_after", pin_ui_o[2:0], 3'b000);
        check_vec("load_busy", busy, 0);
        check_vec("load_x_ready", x_ready, 1);
        check_vec("load_crc", param_crc, exp_crc);

        // ---- inference x=0x3C, result 0x5A ----
        edges.delete();
        pin_uo_i = 8'h5A;
        x_data   = 8'h3C;
        x_valid  = 1'b1;
        @(negedge clk);
        x_valid = 1'b0;
        check_vec("ev_busy", busy, 1);
        t = 1;
        while (!res_valid && t < 60) begin @(negedge clk); t++; end
        check_vec("ev_latency", t - 1, 13);
        check_vec("ev_res_data", res_data, 8'h5A);
        check_vec("ev_edges", edges.size(), 2);
        e0 = (edges.size() > 0) ? edges[0] : 8'h00;
        e1 = (edges.size() > 1) ? edges[1] : 8'h00;
        check_vec("ev_edge_lo", e0, 8'hC1);
        check_vec("ev_edge_hi", e1, 8'h39);
        @(negedge clk);
        check_vec("ev_res_pulse", res_valid, 0);
        check_vec("ev_idle", busy, 0);
        check_vec("ev_crc_held", param_crc, exp_crc);

        // ---- cfg_start wins over x_valid ----
        cfg_start = 1'b1;
        x_valid   = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        x_valid   = 1'b0;
        check_vec("prio_param_ready", param_ready, 1);
        check_vec("prio_loaded", loaded, 0);
        check_vec("prio_crc_clr", param_crc, 8'h00);

        // ---- reset after 5 loaded bits ----
        edges.delete();
        send_byte(8'hFF);
        t = 0;
        while (edges.size() < 5 && t < 100) begin @(negedge clk); t++; end
        check_vec("abort_reach5", (edges.size() >= 5), 1);
        rst = 1'b1;
        @(negedge clk);
        check_vec("abort_pins", pin_ui_o, 8'h00);
        check_vec("abort_loaded", loaded, 0);
        check_vec("abort_busy", busy, 0);
        check_vec("abort_crc", param_crc, 8'h00);
        rst = 1'b0;
        x_data  = 8'h3C;
        x_valid = 1'b1;
        @(negedge clk);
        check_vec("abort_x_ready", x_ready, 0);
        repeat (3) @(negedge clk);
        check_vec("abort_x_ignored", busy, 0);
        x_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bnn_pin_driver
`default_nettype wire
